multiport_array: RTL
====================

MULTIPORT_ARRAY -- requirements
Module: multiport_array

Interface
REQ-001 The block SHALL have parameter s_index, default 4, meaning index width, so num_sets = 2**s_index entries.
REQ-002 The block SHALL have parameter width, default 1, meaning entry width in bits (legal 1..64).
REQ-003 The block SHALL have parameter num_read, default 2, meaning the number of independent read ports (legal 1..4).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port read, input, num_read bits: per-port read enable, where bit p belongs to port p.
REQ-007 The block SHALL have port rindex, input, num_read*s_index bits: packed read indices, where port p uses bits [p*s_index +: s_index].
REQ-008 The block SHALL have port load, input, 1 bit: write request.
REQ-009 The block SHALL have port windex, input, s_index bits: write index.
REQ-010 The block SHALL have port wmask, input, width bits: per-bit write mask, where 1 means that bit takes datain.
REQ-011 The block SHALL have port datain, input, width bits: write data.
REQ-012 The block SHALL have port flush, input, 1 bit: request to clear the whole array by a sequential sweep.
REQ-013 The block SHALL have port dataout, output, num_read*width bits: packed registered read data, where port p uses bits [p*width +: width].
REQ-014 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-015 The block SHALL have port flush_done, output, 1 bit: one-cycle pulse when a sweep completes.

Function
REQ-016 Storage SHALL be num_sets entries of width bits, implemented in logic (flip-flops), not inferred RAM.
REQ-017 A write SHALL be merged as new = (old & ~wmask) | (datain & wmask); wmask = all-ones gives a full-entry write.
REQ-018 Each read port SHALL be registered: dataout[p] updates one cycle after read[p]=1 and otherwise holds its value.
REQ-019 Read-during-write SHALL bypass: if an accepted write targets the same index that port p reads in that cycle, dataout[p] SHALL receive the merged new value, not the old one.
REQ-020 All read ports SHALL operate concurrently and independently; several ports reading the same index all receive the same value.
REQ-021 The FSM SHALL have exactly two states, IDLE and CLEAR; its counter clr_idx is s_index bits wide.
REQ-022 In IDLE with flush=1, the block SHALL go to CLEAR with clr_idx=0; a load in the same cycle SHALL still be performed.
REQ-023 In CLEAR, each cycle SHALL write entry clr_idx to 0 and increment clr_idx; after writing entry num_sets-1 the block SHALL return to IDLE, so CLEAR lasts exactly num_sets cycles.
REQ-024 busy SHALL equal (state == CLEAR).
REQ-025 flush_done SHALL be 1 for exactly the first IDLE cycle after CLEAR, and 0 at all other times.
REQ-026 In CLEAR, load SHALL be ignored (the write is dropped, with no storage change and no bypass) and flush SHALL be ignored.
REQ-027 In CLEAR, reads SHALL remain serviced; a read of index clr_idx in that cycle SHALL return 0 (bypass of the sweep write).
REQ-028 wmask = 0 with load=1 SHALL leave the entry unchanged, and the bypass SHALL return that unchanged old value.

Reset
REQ-029 When rst=1, on the clock edge all entries SHALL become 0, every dataout field SHALL become 0, state SHALL become IDLE, clr_idx SHALL become 0, busy SHALL become 0 and flush_done SHALL become 0.
REQ-030 rst SHALL take priority over load, read and flush in the same cycle; a reset during CLEAR SHALL abort the sweep with no flush_done pulse.

Verification (s_index=4, width=8, num_read=2)
REQ-031 The bench SHALL check a masked write: load idx 3 with datain 0xFF and mask 0xFF, then load idx 3 with datain 0x00 and mask 0x0F, then read port 0 at idx 3 -> dataout[7:0] = 0xF0 one cycle later.
REQ-032 The bench SHALL check bypass: with idx 5 = 0x11, load idx 5 with datain 0xAB and mask 0xFF while port 1 reads idx 5 -> dataout[15:8] = 0xAB next cycle.
REQ-033 The bench SHALL check a dual read: idx 1 = 0x22 and idx 2 = 0x33, read both ports the same cycle -> dataout = 0x3322.
REQ-034 The bench SHALL check a sweep: fill all 16 entries nonzero, pulse flush -> busy high for exactly 16 cycles, flush_done pulses once, and every entry then reads 0.
REQ-035 The bench SHALL check a load during a sweep: load idx 15 with 0x5A on the 3rd CLEAR cycle -> after the sweep, idx 15 reads 0.
REQ-036 The bench SHALL check reset mid-sweep: assert rst on the 8th CLEAR cycle -> busy = 0, flush_done never pulses, dataout = 0, and all entries read 0.

Source files
------------

// File: rtl/multiport_array.sv
// multiport_array: flop array with masked writes, registered read ports with write bypass, and a flush sweep
module multiport_array #(
  parameter int s_index = 4,
  parameter int width = 1,
  parameter int num_read = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [num_read-1:0]         read,
  input  logic [num_read*s_index-1:0] rindex,
  input  logic                        load,
  input  logic [s_index-1:0]          windex,
  input  logic [width-1:0]            wmask,
  input  logic [width-1:0]            datain,
  input  logic                        flush,
  output logic [num_read*width-1:0]   dataout,
  output logic                        busy,
  output logic                        flush_done
);
  localparam int num_sets = 2**s_index;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [s_index-1:0] clr_idx;
  logic [width-1:0] mem [num_sets];
  logic [width-1:0] merged;
  logic [width-1:0] rd_val [num_read];
  logic clearing, wr_en;
  assign clearing = state == CLEAR;
  assign wr_en = load && !clearing;
  assign busy = clearing;
  assign merged = (mem[windex] & ~wmask) | (datain & wmask);
  always_comb state_n = clearing ? (&clr_idx ? IDLE : CLEAR) : (flush ? CLEAR : IDLE);
  always_comb begin
    for (int p = 0; p < num_read; p++)
      rd_val[p] = (clearing && rindex[p*s_index +: s_index] == clr_idx) ? '0 :
                  (wr_en && rindex[p*s_index +: s_index] == windex) ? merged :
                  mem[rindex[p*s_index +: s_index]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_sets; i++) mem[i] <= '0;
      dataout <= '0;
      state <= IDLE;
      clr_idx <= '0;
      flush_done <= 1'b0;
    end else begin
      state <= state_n;
      clr_idx <= clearing ? clr_idx + 1'b1 : '0;
      flush_done <= clearing && &clr_idx;
      if (clearing) mem[clr_idx] <= '0;
      else if (load) mem[windex] <= merged;
      for (int p = 0; p < num_read; p++)
        if (read[p]) dataout[p*width +: width] <= rd_val[p];
    end
  end
endmodule
